seq_det_scheduler: RTL and testbench
====================================

Name: seq_det_scheduler

Overview:
- Time-shares one serial sequence detector (1-bit input stream, 1-bit registered flag output) among NREQ requesters.
- Each requester submits a DW-bit word. The block grants requesters round-robin, clears the detector, and shifts the word in LSB-first.
- It counts flag pulses inside the word's window and returns requester id plus hit count over a valid/ready response port.
- Sits between software-facing request queues and the detector instance.

Parameters:
NREQ, 2, number of requesters (>=2)
IDW, 1, width of requester id, >= clog2(NREQ)
DW, 16, bits per word
CNTW, 5, hit-counter width; must hold DW
FLAG_LAT, 1, cycles from driving a bit on det_a_o to its flag appearing on det_flag_i (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  NREQ  request valid per requester
req_data_i  in  NREQ*DW  requester k word at [k*DW +: DW]
req_ready_o  out  NREQ  one-hot grant/accept
det_a_o  out  1  serial bit to detector input
det_clr_o  out  1  one-cycle detector clear (integrator maps to detector reset)
det_flag_i  in  1  detector flag output
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_id_o  out  IDW  id of requester served
rsp_hits_o  out  CNTW  flag count in window
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE; all outputs 0; counters and shift register 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Reset mid-operation aborts the word: no response issued, captured word dropped.
- FSM IDLE -> CLR -> SHIFT -> DRAIN -> RESP -> IDLE.
- IDLE:
  - req_ready_o is nonzero only in IDLE, and depends combinationally on req_valid_i.
  - Winner is the first valid requester at or after the pointer, wrapping. req_ready_o is one-hot to the winner; all zero if none valid.
  - On handshake: capture word and id, pointer <= winner+1 (wrap at NREQ), go to CLR.
  - A requester may drop valid without a handshake; no effect.
- CLR: det_clr_o=1 and det_a_o=0 for exactly one cycle; hit count <= 0; bit counter <= 0.
- SHIFT:
  - DW cycles; det_a_o = shreg[0], shreg shifts right each cycle. Bit i is driven on SHIFT cycle i.
  - det_a_o=0 in every state other than SHIFT.
- DRAIN: FLAG_LAT cycles; det_a_o=0.
- Window:
  - det_flag_i is sampled only on the DW cycles starting FLAG_LAT cycles after SHIFT cycle 0, i.e. SHIFT cycles FLAG_LAT..DW-1 plus all DRAIN cycles.
  - Flags during IDLE, CLR, RESP or the first FLAG_LAT SHIFT cycles are ignored.
  - Each sampled high increments hits, saturating at 2^CNTW-1.
- RESP:
  - rsp_valid_o=1 with rsp_id_o and rsp_hits_o held stable until rsp_ready_i is high at a clock edge; then IDLE.
  - A new request is not accepted in the RESP handshake cycle: one-cycle bubble minimum.
- Throughput: 1 (IDLE) + 1 + DW + FLAG_LAT + >=1 cycles per word.

Optional Feature:
- Macro SEQ_DET_SCHED_FIRST_HIT_EN.
- When defined:
  - Extra output rsp_first_o [CNTW-1:0] = window index (0..DW-1) of the first sampled flag, or DW if none.
  - It is valid and stable with rsp_valid_o, and reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults, rst_i 2 cycles, then req_valid_i=2'b01 with word 16'h03F9:
   - req_ready_o=2'b01 for one cycle, det_clr_o pulse next cycle.
   - det_a_o over the next 16 cycles = 1,0,0,1,1,1,1,1,1,1,0,0,0,0,0,0.
   - busy_o high from CLR through RESP.
2. Stubbed det_flag_i high on the CLR cycle, on window indices 2, 7 and 15, and on the first RESP cycle -> rsp_hits_o=3, rsp_id_o=0; with SEQ_DET_SCHED_FIRST_HIT_EN, rsp_first_o=2.
3. Both requesters valid continuously for 4 words -> grants 01,10,01,10; rsp_id_o 0,1,0,1.
4. rsp_ready_i held low 5 cycles in RESP -> rsp_valid_o, rsp_id_o and rsp_hits_o stable, req_ready_o=0 despite valid requests; accept occurs on cycle 6.
5. rst_i high for one cycle at SHIFT cycle 8:
   - Next cycle busy_o=0, rsp_valid_o=0, det_a_o=0; no response for the aborted word.
   - With both requesters valid, requester 0 is granted.
6. CNTW=2, flag high on 5 window cycles -> rsp_hits_o=3 (saturated); with macro and no flags, rsp_first_o=16 requires CNTW=5, checked in the default-parameter run.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that time-shares one serial sequence detector and reports per-word hit counts.
// Optional SEQ_DET_SCHED_FIRST_HIT_EN adds rsp_first_o, the window index of the first flag (DW if none).
module seq_det_scheduler #(
    parameter int NREQ     = 2,
    parameter int IDW      = 1,
    parameter int DW       = 16,
    parameter int CNTW     = 5,
    parameter int FLAG_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               det_a_o,
    output logic               det_clr_o,
    input  logic               det_flag_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [IDW-1:0]     rsp_id_o,
    output logic [CNTW-1:0]    rsp_hits_o,
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
    output logic [CNTW-1:0]    rsp_first_o,
`endif
    output logic               busy_o
);

    localparam int CYCW = $clog2(DW + FLAG_LAT + 1);
    localparam logic [CYCW-1:0] LAT_C      = CYCW'(FLAG_LAT);
    localparam logic [CYCW-1:0] SHIFT_LAST = CYCW'(DW - 1);
    localparam logic [CYCW-1:0] DRAIN_LAST = CYCW'(DW + FLAG_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [CNTW-1:0] hits_q, hits_d;
    logic [CYCW-1:0] cyc_q, cyc_d;
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
    logic [CNTW-1:0] first_q, first_d;
`endif

    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [DW-1:0]   grant_word;
    logic            in_window;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // Two passes give "first valid at or after the pointer, then wrap".
    always_comb begin
        grant_vld  = 1'b0;
        grant_id   = '0;
        grant_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_valid_i[k] && (k >= int'(ptr_q))) begin
                grant_vld  = 1'b1;
                grant_id   = IDW'(k);
                grant_word = req_data_i[k*DW +: DW];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_valid_i[k] && (k < int'(ptr_q))) begin
                grant_vld  = 1'b1;
                grant_id   = IDW'(k);
                grant_word = req_data_i[k*DW +: DW];
            end
        end
    end

    // cyc_q counts from SHIFT cycle 0; the window trails it by FLAG_LAT.
    assign in_window = ((state_q == S_SHIFT) || (state_q == S_DRAIN)) && (cyc_q >= LAT_C);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        shreg_d = shreg_q;
        hits_d  = hits_q;
        cyc_d   = cyc_q;
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
        first_d = first_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    id_d    = grant_id;
                    shreg_d = grant_word;
                    ptr_d   = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                hits_d  = '0;
                cyc_d   = '0;
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
                first_d = CNTW'(DW);
`endif
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d = shreg_q >> 1;
                cyc_d   = cyc_q + CYCW'(1);
                if (cyc_q == SHIFT_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + CYCW'(1);
                if (cyc_q == DRAIN_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (in_window && det_flag_i) begin
            hits_d = sat_inc(hits_q);
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
            if (first_q == CNTW'(DW)) begin
                first_d = CNTW'(cyc_q - LAT_C);
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            shreg_q <= '0;
            hits_q  <= '0;
            cyc_q   <= '0;
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
            first_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            shreg_q <= shreg_d;
            hits_q  <= hits_d;
            cyc_q   <= cyc_d;
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
            first_q <= first_d;
`endif
        end
    end

    assign req_ready_o = ((state_q == S_IDLE) && grant_vld) ? (NREQ'(1) << grant_id) : '0;
    assign det_a_o     = (state_q == S_SHIFT) && shreg_q[0];
    assign det_clr_o   = (state_q == S_CLR);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_id_o    = id_q;
    assign rsp_hits_o  = hits_q;
    assign busy_o      = (state_q != S_IDLE);
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
    assign rsp_first_o = first_q;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler: a default instance plus a CNTW=2 instance sharing the same stimulus.
module tb_seq_det_scheduler;

    localparam int NREQ     = 2;
    localparam int IDW      = 1;
    localparam int DW       = 16;
    localparam int CNTW     = 5;
    localparam int FLAG_LAT = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic               det_flag = 1'b0;
    logic               rsp_ready = 1'b0;

    logic [NREQ-1:0] req_ready, req_ready_s;
    logic            det_a, det_a_s, det_clr, det_clr_s;
    logic            rsp_valid, rsp_valid_s, busy, busy_s;
    logic [IDW-1:0]  rsp_id, rsp_id_s;
    logic [CNTW-1:0] rsp_hits;
    logic [1:0]      rsp_hits_s;
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
    logic [CNTW-1:0] rsp_first;
    logic [1:0]      rsp_first_s;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int mdl_ptr = 0;

    always #5 clk = ~clk;

    seq_det_scheduler #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .CNTW(CNTW), .FLAG_LAT(FLAG_LAT)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .det_a_o(det_a), .det_clr_o(det_clr), .det_flag_i(det_flag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_hits_o(rsp_hits),
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
        .rsp_first_o(rsp_first),
`endif
        .busy_o(busy)
    );

    seq_det_scheduler #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .CNTW(2), .FLAG_LAT(FLAG_LAT)) u_sat (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready_s), .det_a_o(det_a_s), .det_clr_o(det_clr_s), .det_flag_i(det_flag),
        .rsp_valid_o(rsp_valid_s), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id_s), .rsp_hits_o(rsp_hits_s),
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
        .rsp_first_o(rsp_first_s),
`endif
        .busy_o(busy_s)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (ptr + i) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic noise_bit(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return logic'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic apply_reset(input int n);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; det_flag = 1'b0;
        repeat (n) @(posedge clk);
        #1; rst = 1'b0; mdl_ptr = 0;
        #1;
    endtask

    // One full word: handshake, clear, shift, drain, response with optional stall.
    task automatic run_word(input logic [NREQ-1:0] vmask, input logic [DW-1:0] wmask,
                            input int mode, input int stall, output int obs_id);
        int win, exp_hits, exp_sat, exp_first;
        logic [NREQ-1:0] exp_rdy;
        logic [DW-1:0] word;
        obs_id = -1;
        win = rr_pick(mdl_ptr, vmask);
        exp_rdy = NREQ'(1) << win;
        word = req_data[win*DW +: DW];
        exp_hits = $countones(wmask);
        exp_sat = (exp_hits > 3) ? 3 : exp_hits;
        exp_first = DW;
        for (int j = DW - 1; j >= 0; j--) if (wmask[j]) exp_first = j;
        mdl_ptr = (win + 1) % NREQ;

        req_valid = vmask; rsp_ready = 1'b0; det_flag = noise_bit(mode);
        #1;
        n_chk++;
        if ({busy, req_ready, req_ready_s} !== {1'b0, exp_rdy, exp_rdy}) begin
            n_fail++;
            $display("FAIL grant: got busy/ready %b/%b expected 0/%b", busy, req_ready, exp_rdy);
        end

        @(posedge clk); #1;
        det_flag = noise_bit(mode);
        #1;
        n_chk++;
        if ({det_clr, det_a, busy, req_ready} !== {1'b1, 1'b0, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL clr_cycle: got clr/a/busy/ready %b%b%b%b expected 1010", det_clr, det_a, busy, req_ready);
        end

        for (int i = 0; i < DW; i++) begin
            @(posedge clk); #1;
            det_flag = (i >= FLAG_LAT) ? wmask[i-FLAG_LAT] : noise_bit(mode);
            #1;
            n_chk++;
            if ({det_clr, det_a, busy, req_ready, det_a_s} !== {1'b0, word[i], 1'b1, 2'b00, word[i]}) begin
                n_fail++;
                $display("FAIL shift[%0d]: got clr/a/busy/ready %b%b%b%b expected 0%b100", i, det_clr, det_a, busy, req_ready, word[i]);
            end
        end

        for (int d = 0; d < FLAG_LAT; d++) begin
            @(posedge clk); #1;
            det_flag = wmask[DW-FLAG_LAT+d];
            #1;
            n_chk++;
            if ({det_clr, det_a, busy, rsp_valid} !== 4'b0010) begin
                n_fail++;
                $display("FAIL drain[%0d]: got clr/a/busy/valid %b%b%b%b expected 0010", d, det_clr, det_a, busy, rsp_valid);
            end
        end

        for (int s = 0; s <= stall; s++) begin
            @(posedge clk); #1;
            rsp_ready = (s == stall);
            det_flag = noise_bit(mode);
            #1;
            obs_id = int'(rsp_id);
            n_chk++;
            if ({rsp_valid, rsp_id, rsp_hits, busy, req_ready, det_a, det_clr} !==
                {1'b1, IDW'(win), CNTW'(exp_hits), 1'b1, 2'b00, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL resp[%0d]: got valid=%b id=%0d hits=%0d ready=%b expected valid=1 id=%0d hits=%0d ready=00",
                         s, rsp_valid, rsp_id, rsp_hits, req_ready, win, exp_hits);
            end
            n_chk++;
            if ({rsp_valid_s, rsp_id_s, rsp_hits_s} !== {1'b1, IDW'(win), 2'(exp_sat)}) begin
                n_fail++;
                $display("FAIL resp_sat[%0d]: got valid=%b id=%0d hits=%0d expected 1/%0d/%0d",
                         s, rsp_valid_s, rsp_id_s, rsp_hits_s, win, exp_sat);
            end
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
            n_chk++;
            if (rsp_first !== CNTW'(exp_first)) begin
                n_fail++;
                $display("FAIL resp_first[%0d]: got %0d expected %0d", s, rsp_first, exp_first);
            end
`endif
        end

        @(posedge clk); #1;
        rsp_ready = 1'b0; det_flag = 1'b0;
        #1;
        n_chk++;
        if ({busy, rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_resp_idle: got busy/valid %b%b expected 00", busy, rsp_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_chk++;
        if ({req_ready, det_a, det_clr, rsp_valid, rsp_id, rsp_hits, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b a=%b clr=%b valid=%b id=%0d hits=%0d busy=%b expected all 0",
                     req_ready, det_a, det_clr, rsp_valid, rsp_id, rsp_hits, busy);
        end
        n_chk++;
        if ({req_ready_s, rsp_valid_s, rsp_hits_s, busy_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_sat_outputs: got ready=%b valid=%b hits=%0d busy=%b expected all 0",
                     req_ready_s, rsp_valid_s, rsp_hits_s, busy_s);
        end
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
        n_chk++;
        if (rsp_first !== '0) begin
            n_fail++;
            $display("FAIL reset_first: got %0d expected 0", rsp_first);
        end
`endif
    endtask

    task automatic test_shift_pattern();
        int id;
        req_data = {16'hA5C3, 16'h03F9};
        run_word(2'b01, 16'h0000, 0, 0, id);
    endtask

    task automatic test_window();
        int id;
        req_data = {16'h1234, 16'hBEEF};
        run_word(2'b01, 16'h8084, 2, 0, id);
    endtask

    task automatic test_round_robin();
        int id;
        apply_reset(1);
        req_data = {16'h5A5A, 16'hC0DE};
        for (int w = 0; w < 4; w++) begin
            run_word(2'b11, DW'($urandom), 1, 0, id);
            n_chk++;
            if (id !== (w % 2)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got id %0d expected %0d", w, id, w % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int id;
        req_data = {16'h0F0F, 16'hF00D};
        run_word(2'b11, 16'h4211, 1, 5, id);
    endtask

    task automatic test_abort();
        int id;
        bit seen;
        req_valid = 2'b01; req_data = {16'hFFFF, 16'hFFFF}; det_flag = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_grant: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0; det_flag = 1'b0;
        #1;
        n_chk++;
        if ({busy, rsp_valid, det_a, det_clr, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b valid=%b a=%b clr=%b ready=%b expected all 0",
                     busy, rsp_valid, det_a, det_clr, req_ready);
        end
        seen = 1'b0;
        repeat (24) begin
            @(posedge clk); #2;
            if (rsp_valid || busy) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_resp: got activity %b expected 0", seen);
        end
        mdl_ptr = 0;
        req_valid = 2'b11;
        #1;
        n_chk++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_regrant: got %b expected 01", req_ready);
        end
        run_word(2'b11, 16'h0001, 0, 0, id);
    endtask

    task automatic test_saturation();
        int id;
        req_data = {16'h3C3C, 16'h9999};
        run_word(2'b10, 16'b0000_1000_1001_0101, 0, 1, id);
    endtask

    task automatic test_random();
        int id;
        for (int n = 0; n < 8; n++) begin
            req_valid = '0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
                n_chk++;
                if ({busy, req_ready} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rand_idle[%0d]: got busy/ready %b%b expected 000", n, busy, req_ready);
                end
            end
            req_data = {16'($urandom), 16'($urandom)};
            run_word(2'($urandom_range(1, 3)), DW'($urandom), 1, $urandom_range(0, 3), id);
        end
    endtask

    initial begin
        test_reset();
        test_shift_pattern();
        test_window();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
